clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Button-driven time-set controller for the binary clock.
- Sequences the user through setting hours, then minutes, from two push buttons.
- While a field is being set, the clock counters are frozen and the field being edited blinks on the display.
- On commit, the edited values are handed to the clock counters via a one-cycle load strobe.
- Sits between the raw button inputs and the hours/minutes counters; runs on the same 100 Hz tick clock.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable samples required before a button level is accepted.
- TIMEOUT_CYCLES, 3000: idle cycles in a set state before aborting back to RUN (30 s at 100 Hz).
- BLINK_HALF, 25: cycles per blink half-period.
- REPEAT_DELAY, 50: hold cycles before auto-repeat starts. Used only with the optional feature.
- REPEAT_RATE, 10: cycles between auto-repeat increments. Used only with the optional feature.

Ports:
- clk  in  1  system clock (100 Hz tick); all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_mode  in  1  raw mode button, asynchronous, active-high.
- btn_inc  in  1  raw increment button, asynchronous, active-high.
- cur_hours  in  5  live hours value from the clock (0..23).
- cur_minutes  in  6  live minutes value from the clock (0..59).
- set_hours  out  5  shadow hours presented for load.
- set_minutes  out  6  shadow minutes presented for load.
- load  out  1  one-cycle strobe: clock counters take set_hours/set_minutes.
- hold  out  1  freeze clock counting while high.
- blank_mask  out  2  [1] blank hours field, [0] blank minutes field.
- mode  out  2  FSM state encoding.

Behaviour:
- Reset: all outputs 0; FSM enters RUN; shadow regs, timers and debouncers are cleared. The debounced button level is 0.
- Input conditioning: each button passes through a 2-flop synchronizer, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples differing from the current level.
  - A press pulse is a 0->1 transition of the debounced level, one cycle wide.
  - Raw press to press pulse latency = 2 + DEBOUNCE_CYCLES cycles.
- FSM states, with mode encoding:
  - RUN = 0: hold=0, blank_mask=0. Mode press -> capture cur_hours/cur_minutes into shadow, go to SET_H. Inc press is ignored.
  - SET_H = 1: hold=1. Inc press -> shadow hours +1, wrapping 23->0. Mode press -> SET_M.
  - SET_M = 2: hold=1. Inc press -> shadow minutes +1, wrapping 59->0. Mode press -> COMMIT.
  - COMMIT = 3: load=1 and hold=1 for exactly one cycle, then RUN unconditionally. Button presses in this cycle are ignored.
- Capture clamping: cur_hours >23 is captured as 0; cur_minutes >59 is captured as 0.
- Simultaneous mode and inc press pulses in the same cycle: mode wins, the inc press is dropped.
- Timeout:
  - The idle counter clears on entry to SET_H/SET_M and on any press pulse.
  - Reaching TIMEOUT_CYCLES in SET_H or SET_M -> RUN with no load. Shadow values are discarded and hold drops the next cycle.
- Blink:
  - A free-running phase toggles every BLINK_HALF cycles; it is reset to the visible phase on each state entry and on each press pulse.
  - SET_H: blank_mask[1] = phase. SET_M: blank_mask[0] = phase. Otherwise both bits are 0.
- set_hours/set_minutes always reflect the shadow regs; they only matter when load=1.
- Reset mid-edit: returns immediately to RUN with hold=0 and no load.

Optional Feature:
- Macro: CLOCK_SET_AUTOREPEAT_EN.
- Defined:
  - In SET_H/SET_M, holding debounced inc high for REPEAT_DELAY cycles after its press pulse starts auto-repeat.
  - Auto-repeat generates an additional increment every REPEAT_RATE cycles until release.
  - Repeat increments reset the timeout counter and the blink phase like real presses.
  - Mode press still has priority over a repeat increment in the same cycle.
- Undefined: only press pulses increment; the REPEAT_* parameters are unused and no repeat logic is built.

Test Plan:
- Reset, then idle 100 cycles -> outputs all 0, mode=0, no load.
- cur=12:34; mode press; 3 inc presses; mode press; 2 inc presses; mode press -> load pulses one cycle with set_hours=15, set_minutes=36; hold high from SET_H entry through the COMMIT cycle.
- Shadow hours=23, inc press -> 0; shadow minutes=59, inc press -> 0.
- btn_inc bouncing 1-cycle glitches for 3 cycles -> no increment; a stable press -> exactly one increment, 6 cycles after the raw edge.
- Enter SET_H, then no presses for 3000 cycles -> back to mode=0, hold=0, load never asserted; cur values unchanged.
- Mode and inc press pulses in the same cycle in SET_H -> mode=2, hours unchanged. With CLOCK_SET_AUTOREPEAT_EN, inc held 80 cycles in SET_M from minutes=0 -> minutes=4 (1 press + repeats at +50, +60, +70).

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Button-driven time-set controller for the binary clock.
// Walks the user through hours then minutes, freezes the clock counters while
// editing, blinks the field being edited and hands the result over with a
// one-cycle load strobe.
// Optional auto-repeat on a held inc button: define CLOCK_SET_AUTOREPEAT_EN.
module clock_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 3000,
  parameter int unsigned BLINK_HALF      = 25,
  parameter int unsigned REPEAT_DELAY    = 50,
  parameter int unsigned REPEAT_RATE     = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_inc,
  input  logic [4:0] i_cur_hours,
  input  logic [5:0] i_cur_minutes,
  output logic [4:0] o_set_hours,
  output logic [5:0] o_set_minutes,
  output logic       o_load,
  output logic       o_hold,
  output logic [1:0] o_blank_mask,
  output logic [1:0] o_mode
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned IdleW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StSetH   = 2'd1,
    StSetM   = 2'd2,
    StCommit = 2'd3
  } state_e;

  // Button index 0 = mode, 1 = inc
  logic [1:0]       r_sync1, r_sync2, r_level;
  logic [DbW-1:0]   r_db_cnt [2];
  logic [1:0]       w_flip, w_level_d, w_rise;

  state_e           r_state, w_state_d;
  logic [4:0]       r_hours, w_hours_d;
  logic [5:0]       r_minutes, w_minutes_d;
  logic [IdleW-1:0] r_idle;
  logic [BlinkW-1:0] r_blink_cnt;
  logic             r_phase;

  logic w_press_mode, w_press_inc, w_rep, w_inc_evt, w_any_press;
  logic w_in_set, w_idle_hit, w_state_chg;

  // Debounce decision: flip the level on the Nth consecutive differing sample
  always_comb begin
    w_flip    = '0;
    w_level_d = '0;
    w_rise    = '0;
    for (int b = 0; b < 2; b++) begin
      w_flip[b]    = (r_sync2[b] != r_level[b]) &&
                     (r_db_cnt[b] == DbW'(DEBOUNCE_CYCLES - 1));
      w_level_d[b] = r_level[b] ^ w_flip[b];
      w_rise[b]    = w_flip[b] & ~r_level[b];
    end
  end

  // Two-flop synchronizers and debounce run-length counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      for (int b = 0; b < 2; b++) r_db_cnt[b] <= '0;
    end else begin
      r_sync1 <= {i_btn_inc, i_btn_mode};
      r_sync2 <= r_sync1;
      r_level <= w_level_d;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_level[b] || w_flip[b]) r_db_cnt[b] <= '0;
        else                                       r_db_cnt[b] <= r_db_cnt[b] + DbW'(1);
      end
    end
  end

  // Press pulse is the debounced rising edge, acted on at the edge it occurs
  assign w_press_mode = w_rise[0];
  assign w_press_inc  = w_rise[1];
  assign w_in_set     = (r_state == StSetH) || (r_state == StSetM);

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_DELAY + 1);
  logic [RepW-1:0] r_rep_cnt;
  logic            w_rep_tick;

  assign w_rep_tick = (r_rep_cnt == RepW'(REPEAT_DELAY)) && w_level_d[1];
  assign w_rep      = w_rep_tick && w_in_set;

  // Hold timer: cycles since the inc press, reloaded so ticks recur every REPEAT_RATE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rep_cnt <= '0;
    end else if (w_press_inc) begin
      r_rep_cnt <= RepW'(1);
    end else if (!w_level_d[1]) begin
      r_rep_cnt <= '0;
    end else if (w_rep_tick) begin
      r_rep_cnt <= RepW'(REPEAT_DELAY - REPEAT_RATE + 1);
    end else if (r_rep_cnt != RepW'(REPEAT_DELAY)) begin
      r_rep_cnt <= r_rep_cnt + RepW'(1);
    end
  end
`else
  // Repeat parameters referenced only so they stay part of the interface
  assign w_rep = 1'b0 & (REPEAT_DELAY == 0) & (REPEAT_RATE == 0);
`endif

  assign w_inc_evt   = (w_press_inc | w_rep) & ~w_press_mode;
  assign w_any_press = w_press_mode | w_press_inc | w_rep;
  assign w_idle_hit  = (r_idle == IdleW'(TIMEOUT_CYCLES - 1));
  assign w_state_chg = (w_state_d != r_state);

  // Next-state and shadow register update
  always_comb begin
    w_state_d   = r_state;
    w_hours_d   = r_hours;
    w_minutes_d = r_minutes;
    unique case (r_state)
      StRun: begin
        if (w_press_mode) begin
          w_hours_d   = (i_cur_hours > 5'd23)   ? 5'd0 : i_cur_hours;
          w_minutes_d = (i_cur_minutes > 6'd59) ? 6'd0 : i_cur_minutes;
          w_state_d   = StSetH;
        end
      end
      StSetH: begin
        if (w_press_mode)    w_state_d = StSetM;
        else if (w_inc_evt)  w_hours_d = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
        else if (w_idle_hit) w_state_d = StRun;
      end
      StSetM: begin
        if (w_press_mode)    w_state_d   = StCommit;
        else if (w_inc_evt)  w_minutes_d = (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
        else if (w_idle_hit) w_state_d   = StRun;
      end
      StCommit: w_state_d = StRun;
      default:  w_state_d = StRun;
    endcase
  end

  // FSM state and shadow registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StRun;
      r_hours   <= '0;
      r_minutes <= '0;
    end else begin
      r_state   <= w_state_d;
      r_hours   <= w_hours_d;
      r_minutes <= w_minutes_d;
    end
  end

  // Idle timer: counts only while editing, restarts on entry or any press
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idle <= '0;
    end else if (w_state_chg || w_any_press || !w_in_set) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IdleW'(1);
    end
  end

  // Blink phase: free running, forced visible on state entry or any press
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_state_chg || w_any_press) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BlinkW'(BLINK_HALF - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BlinkW'(1);
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    o_mode        = r_state;
    o_hold        = (r_state != StRun);
    o_load        = (r_state == StCommit);
    o_blank_mask  = {(r_state == StSetH) & r_phase, (r_state == StSetM) & r_phase};
    o_set_hours   = r_hours;
    o_set_minutes = r_minutes;
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: per-cycle reference model plus
// hand-computed literal expectations. Honours CLOCK_SET_AUTOREPEAT_EN.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hours = '0;
  logic [5:0] cur_minutes = '0;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       load, hold;
  logic [1:0] blank_mask, mode;

  int checks = 0;
  int errors = 0;

  clock_set_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_btn_mode   (btn_mode),
    .i_btn_inc    (btn_inc),
    .i_cur_hours  (cur_hours),
    .i_cur_minutes(cur_minutes),
    .o_set_hours  (set_hours),
    .o_set_minutes(set_minutes),
    .o_load       (load),
    .o_hold       (hold),
    .o_blank_mask (blank_mask),
    .o_mode       (mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state (spec-level: raw sample windows, integer fields)
  bit         mdl_on = 1'b0;
  int         m_st = 0, m_h = 0, m_m = 0, m_idle = 0, m_blink = 0, m_held = 0;
  logic [5:0] hm = '0, hi = '0;
  logic       lm = 1'b0, li = 1'b0;

  // Debounced level: flips once the last four synchronized samples all disagree
  function automatic logic deb(input logic [5:0] h, input logic lvl);
    if (!lvl && h[5:2] == 4'b1111) return 1'b1;
    if (lvl && h[5:2] == 4'b0000)  return 1'b0;
    return lvl;
  endfunction

  task automatic model_step();
    logic nm, ni, rise_m, rise_i, rep, inc_evt, anyp;
    int prev;
    if (rst) begin
      mdl_on = 1'b1;
      m_st = 0; m_h = 0; m_m = 0; m_idle = 0; m_blink = 0; m_held = 0;
      hm = '0; hi = '0; lm = 1'b0; li = 1'b0;
      return;
    end
    hm = {hm[4:0], btn_mode};
    hi = {hi[4:0], btn_inc};
    nm = deb(hm, lm);
    ni = deb(hi, li);
    rise_m = nm & ~lm;
    rise_i = ni & ~li;
    rep = 1'b0;
`ifdef CLOCK_SET_AUTOREPEAT_EN
    if (rise_i)  m_held = 0;
    else if (ni) m_held++;
    else         m_held = 0;
    rep = !rise_i && ni && (m_st == 1 || m_st == 2) && m_held >= 50 && (m_held - 50) % 10 == 0;
`endif
    inc_evt = (rise_i || rep) && !rise_m;
    anyp = rise_m || rise_i || rep;
    prev = m_st;
    case (m_st)
      0: if (rise_m) begin
        m_h = (cur_hours > 23) ? 0 : int'(cur_hours);
        m_m = (cur_minutes > 59) ? 0 : int'(cur_minutes);
        m_st = 1;
      end
      1: if (rise_m) m_st = 2;
         else if (inc_evt) m_h = (m_h + 1) % 24;
         else if (m_idle == 2999) m_st = 0;
      2: if (rise_m) m_st = 3;
         else if (inc_evt) m_m = (m_m + 1) % 60;
         else if (m_idle == 2999) m_st = 0;
      default: m_st = 0;
    endcase
    if (m_st != prev || anyp || !(m_st == 1 || m_st == 2)) m_idle = 0;
    else m_idle++;
    if (m_st != prev || anyp) m_blink = 0;
    else m_blink++;
    lm = nm;
    li = ni;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare against the model, plus load strobe capture
  int         load_cnt = 0;
  logic [4:0] ld_h = '0;
  logic [5:0] ld_m = '0;
  initial forever begin
    logic phase;
    logic [1:0] emask;
    @(negedge clk);
    if (load) begin
      load_cnt++;
      ld_h = set_hours;
      ld_m = set_minutes;
    end
    if (mdl_on) begin
      phase = ((m_blink / 25) % 2) == 1;
      emask = (m_st == 1) ? {phase, 1'b0} : (m_st == 2) ? {1'b0, phase} : 2'b00;
      chk("cycle_model",
          {15'd0, mode, hold, load, blank_mask, set_hours, set_minutes},
          {15'd0, 2'(m_st), m_st != 0, m_st == 3, emask, 5'(m_h), 6'(m_m)});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; cyc(10);
    btn_mode = 1'b0; cyc(10);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; cyc(10);
    btn_inc = 1'b0; cyc(10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_m;
    // Reset and idle
    cyc(3);
    rst = 1'b0;
    cyc(100);
    chk("idle_mode", mode, 0);
    chk("idle_hold", hold, 0);
    chk("idle_mask", blank_mask, 0);
    chk("idle_loads", load_cnt, 0);

    // 12:34 -> +3 hours, +2 minutes -> load 15:36
    cur_hours = 5'd12; cur_minutes = 6'd34;
    press_mode();
    chk("capture_h", set_hours, 12);
    chk("capture_m", set_minutes, 34);
    chk("seth_hold", hold, 1);
    repeat (3) press_inc();
    chk("hours_15", set_hours, 15);
    press_mode();
    chk("setm_mode", mode, 2);
    repeat (2) press_inc();
    chk("minutes_36", set_minutes, 36);
    press_mode();
    chk("load_once", load_cnt, 1);
    chk("load_h", ld_h, 15);
    chk("load_m", ld_m, 36);
    chk("back_run", mode, 0);

    // Wrap 23 -> 0 and 59 -> 0
    cur_hours = 5'd23; cur_minutes = 6'd59;
    press_mode();
    press_inc();
    chk("wrap_h", set_hours, 0);
    press_mode();
    press_inc();
    chk("wrap_m", set_minutes, 0);
    press_mode();
    chk("load_two", load_cnt, 2);

    // Out-of-range capture clamps, glitches, latency, simultaneous presses
    cur_hours = 5'd27; cur_minutes = 6'd62;
    press_mode();
    chk("clamp_h", set_hours, 0);
    chk("clamp_m", set_minutes, 0);
    repeat (3) begin
      btn_inc = 1'b1; cyc(1);
      btn_inc = 1'b0; cyc(1);
    end
    cyc(10);
    chk("glitch_ignored", set_hours, 0);
    btn_inc = 1'b1;
    cyc(5);
    chk("latency_before", set_hours, 0);
    cyc(1);
    chk("latency_at6", set_hours, 1);
    btn_inc = 1'b0; cyc(10);
    btn_mode = 1'b1; btn_inc = 1'b1;
    cyc(6);
    chk("simul_mode", mode, 2);
    chk("simul_hours", set_hours, 1);
    btn_mode = 1'b0; btn_inc = 1'b0; cyc(10);
    press_mode();
    chk("load_three", load_cnt, 3);
    chk("load3_h", ld_h, 1);

    // Blink timing and 3000-cycle timeout
    cur_hours = 5'd8; cur_minutes = 6'd8;
    btn_mode = 1'b1;
    cyc(6);
    btn_mode = 1'b0;
    chk("to_enter", mode, 1);
    chk("blink_visible0", blank_mask, 2'b00);
    cyc(24);
    chk("blink_visible24", blank_mask, 2'b00);
    cyc(1);
    chk("blink_blank25", blank_mask, 2'b10);
    cyc(2974);
    chk("to_still_set", mode, 1);
    cyc(1);
    chk("to_run", mode, 0);
    chk("to_hold", hold, 0);
    chk("to_noload", load_cnt, 3);

    // Held inc for 80 cycles in SET_M from minutes 0
    cur_hours = 5'd0; cur_minutes = 6'd0;
    press_mode();
    press_mode();
    btn_inc = 1'b1; cyc(80);
    btn_inc = 1'b0; cyc(12);
`ifdef CLOCK_SET_AUTOREPEAT_EN
    exp_m = 4;
`else
    exp_m = 1;
`endif
    chk("held_inc", set_minutes, exp_m);
    press_mode();
    chk("load_four", load_cnt, 4);

    // Reset mid-edit
    press_mode();
    chk("edit_hold", hold, 1);
    rst = 1'b1;
    #1;
    chk("rst_hold", hold, 0);
    chk("rst_mode", mode, 0);
    chk("rst_load", load, 0);
    cyc(2);
    rst = 1'b0;
    cyc(5);
    chk("rst_stay_run", mode, 0);
    chk("rst_noload", load_cnt, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
